// File: rtl/gray_to_yuv422.sv
// Gray-to-YUV422 packer: luma passes through, constant Cb/Cr alternate by pixel phase.
// One-cycle latency through a two-entry register slice; input ready is a flop, so output stalls never reach it combinationally.
module gray_to_yuv422 #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PPC        = 4,
  parameter logic [DATA_WIDTH-1:0] U_VALUE    = {1'b1, {(DATA_WIDTH-1){1'b0}}},
  parameter logic [DATA_WIDTH-1:0] V_VALUE    = {1'b1, {(DATA_WIDTH-1){1'b0}}}
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [DATA_WIDTH*PPC-1:0] s_axis_gray_tdata,
  input  logic                      s_axis_gray_tvalid,
  input  logic                      s_axis_gray_tuser,
  input  logic                      s_axis_gray_tlast,
  output logic                      s_axis_gray_tready,
  output logic [DATA_WIDTH*PPC*3-1:0] m_axis_yuv_tdata,
  output logic                      m_axis_yuv_tvalid,
  output logic                      m_axis_yuv_tuser,
  output logic                      m_axis_yuv_tlast,
  input  logic                      m_axis_yuv_tready
);

  localparam int   IW      = DATA_WIDTH * PPC;
  localparam int   OW      = 2 * IW;
  localparam logic PPC_ODD = 1'((PPC % 2) == 1);

  typedef struct packed {
    logic          user;
    logic          last;
    logic [OW-1:0] dat;
  } beat_t;

  beat_t r_out;
  beat_t r_skid;
  beat_t w_in_beat;
  logic  r_out_vld;
  logic  r_skid_vld;
  logic  r_s_rdy;
  logic  r_phase;
  logic  w_beat_phase;
  logic  w_next_phase;
  logic  w_in_acc;
  logic  w_out_load;
  logic  w_skid_load;
  logic  w_skid_vld_nxt;

  // Start-of-frame forces even phase for this beat; end-of-line forces it for the next.
  always_comb begin
    w_in_beat      = '0;
    w_in_beat.user = s_axis_gray_tuser;
    w_in_beat.last = s_axis_gray_tlast;
    w_beat_phase   = r_phase & ~s_axis_gray_tuser;
    for (int i = 0; i < PPC; i++) begin
      w_in_beat.dat[i*2*DATA_WIDTH +: 2*DATA_WIDTH] =
        {((w_beat_phase ^ 1'(i)) ? V_VALUE : U_VALUE),
         s_axis_gray_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
    end
    w_next_phase = s_axis_gray_tlast ? 1'b0 : (w_beat_phase ^ PPC_ODD);
  end

  assign w_in_acc       = s_axis_gray_tvalid & r_s_rdy;
  assign w_out_load     = ~r_out_vld | m_axis_yuv_tready;
  assign w_skid_load    = w_in_acc & ~w_out_load;
  assign w_skid_vld_nxt = w_skid_load | (r_skid_vld & ~w_out_load);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_s_rdy    <= 1'b0;
      r_phase    <= 1'b0;
    end else begin
      if (w_in_acc) begin
        r_phase <= w_next_phase;
      end
      // Skid has priority over the input so beat order is preserved.
      if (w_out_load) begin
        if (r_skid_vld) begin
          r_out <= r_skid;
        end else if (w_in_acc) begin
          r_out <= w_in_beat;
        end
        r_out_vld <= r_skid_vld | w_in_acc;
      end
      if (w_skid_load) begin
        r_skid <= w_in_beat;
      end
      r_skid_vld <= w_skid_vld_nxt;
      r_s_rdy    <= ~w_skid_vld_nxt;
    end
  end

  assign s_axis_gray_tready = r_s_rdy;
  assign m_axis_yuv_tdata   = {{IW{1'b0}}, r_out.dat};
  assign m_axis_yuv_tvalid  = r_out_vld;
  assign m_axis_yuv_tuser   = r_out.user;
  assign m_axis_yuv_tlast   = r_out.last;

endmodule

// File: doc/gray_to_yuv422.md
GRAY_TO_YUV422 -- requirements
Module: gray_to_yuv422

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per component.
REQ-002 Parameter PPC, default 4: pixels per beat; legal range 1..8, odd values allowed.
REQ-003 Parameter U_VALUE, default 2**(DATA_WIDTH-1): constant Cb inserted for even-phase pixels.
REQ-004 Parameter V_VALUE, default 2**(DATA_WIDTH-1): constant Cr inserted for odd-phase pixels.
REQ-005 aclk  in  1  sole clock; all logic on rising edge.
REQ-006 areset  in  1  synchronous, active-high reset.
REQ-007 s_axis_gray_tdata  in  DATA_WIDTH*PPC  gray pixels; pixel i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 s_axis_gray_tvalid / tuser / tlast  in  1 each  AXI4-Stream valid, start-of-frame, end-of-line.
REQ-009 s_axis_gray_tready  out  1  registered ready.
REQ-010 m_axis_yuv_tdata  out  DATA_WIDTH*PPC*3  YUV422 beat; pixel i at [i*2*DATA_WIDTH +: 2*DATA_WIDTH], Y in low DATA_WIDTH bits, chroma in high DATA_WIDTH bits; bits [DATA_WIDTH*PPC*3-1 : DATA_WIDTH*PPC*2] always zero.
REQ-011 m_axis_yuv_tvalid / tuser / tlast  out  1 each  registered AXI4-Stream sideband.
REQ-012 m_axis_yuv_tready  in  1  downstream ready.

Function
REQ-013 Y of output pixel i SHALL equal input pixel i unmodified; no arithmetic on luma.
REQ-014 Chroma of output pixel i SHALL be U_VALUE when (phase + i) is even, V_VALUE when odd, where phase is the 1-bit chroma phase of the beat.
REQ-015 Phase SHALL be 0 for any beat with tuser=1 and for the first beat after a beat with tlast=1; otherwise phase of next beat = phase XOR (PPC mod 2).
REQ-016 Phase register SHALL update only on an accepted input beat (tvalid & tready).
REQ-017 Datapath SHALL be a two-entry register slice (main output register + skid register); latency from input acceptance to m_axis_yuv_tvalid SHALL be exactly 1 cycle when output is not stalled.
REQ-018 s_axis_gray_tready SHALL be driven from a flop, equal to NOT skid_valid; no combinational path from m_axis_yuv_tready to s_axis_gray_tready.
REQ-019 Sustained throughput SHALL be one beat per cycle while m_axis_yuv_tready=1.
REQ-020 If the output is valid and stalled while an input beat is accepted, that beat SHALL be held in skid; s_axis_gray_tready SHALL deassert the following cycle.
REQ-021 On output handshake with skid full, skid contents SHALL move to the output register in the same edge; s_axis_gray_tready SHALL reassert next cycle.
REQ-022 m_axis_yuv_tdata/tuser/tlast SHALL remain stable while tvalid=1 and tready=0.
REQ-023 Beats SHALL be neither dropped, duplicated nor reordered; tuser/tlast travel with their beat.
REQ-024 Simultaneous output handshake and input acceptance with skid empty SHALL load the new beat directly into the output register.
REQ-025 tuser and tlast on the same beat SHALL both be honored (phase 0 for that beat and for the next).

Reset
REQ-026 While areset=1: m_axis_yuv_tvalid=0, tuser=0, tlast=0, tdata=0, s_axis_gray_tready=0, skid empty, phase=0.
REQ-027 s_axis_gray_tready SHALL be 1 on the first cycle after areset deasserts.
REQ-028 Reset asserted mid-stream SHALL discard both buffered beats; no partial beat emitted afterwards.

Verification
REQ-029 W=8, PPC=4, defaults: input 0x40302010, tuser=1 -> one cycle later tdata = 0x00000000_80408030_80208010, tuser=1.
REQ-030 PPC=3, U=0x55, V=0xAA: beats A, B, C(tlast), D -> chroma A={55,AA,55}, B={AA,55,AA}, C={55,AA,55}, D={55,AA,55}.
REQ-031 Streaming 100 beats with m_tready toggling pseudo-randomly -> output sequence identical to input, tready never combinationally follows m_tready, no loss.
REQ-032 Hold m_tready=0 with s_tvalid=1 -> exactly two beats accepted, s_tready=0 from the cycle after the second; release -> beats emerge in order, s_tready=1 next cycle.
REQ-033 Assert areset for 1 cycle with both registers full -> tvalid=0 next cycle, next emitted beat is the first post-reset input, phase 0.
REQ-034 Beat with tuser=1 and tlast=1 at PPC=3 -> that beat and the following beat both start with U_VALUE.
